// File: rtl/glb_pkg.sv
// Shared constants and types for the glb_read capture block.
package glb_pkg;

    localparam int          GLB_DATA_W     = 17;
    localparam int          GLB_CNT_W      = 12;
    localparam int          GLB_ADDR_W     = 11;
    localparam logic [16:0] GLB_DONE_TOKEN = 17'h10100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RECV  = 2'd2,
        DONE  = 2'd3
    } glb_rd_state_t;

    // Clamp the requested word count to the buffer depth.
    function automatic logic [GLB_CNT_W-1:0] glb_clamp_lim(
        input logic [GLB_CNT_W-1:0] tx_size,
        input logic [GLB_CNT_W-1:0] depth
    );
        return (tx_size > depth) ? depth : tx_size;
    endfunction

endpackage

// File: rtl/glb_read_if.sv
// Stream, control and backdoor-read signals of glb_read.
// Handshake: a word moves on a rising clk edge where valid=1 and ready=1;
// ready is registered and never depends on valid in the same cycle, and the
// upstream side may hold valid high and change data only after an accepting edge.
interface glb_read_if;
    import glb_pkg::*;

    logic                  flush;
    logic [GLB_CNT_W-1:0]  tx_size;
    logic [GLB_DATA_W-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  done;
    logic [GLB_CNT_W-1:0]  num_rx;
    logic [GLB_ADDR_W-1:0] rd_addr;
    logic [GLB_DATA_W-1:0] rd_data;
    glb_rd_state_t         dbg_state;

    modport master (
        output flush, tx_size, data, valid, rd_addr,
        input  ready, done, num_rx, rd_data, dbg_state
    );

    modport slave (
        input  flush, tx_size, data, valid, rd_addr,
        output ready, done, num_rx, rd_data, dbg_state
    );

endinterface

// File: rtl/glb_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to pace random sink stalls.
module glb_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    output logic [15:0] o_value
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign o_value = r_lfsr;

    // Shift in the feedback bit every enabled cycle; reload the seed on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else if (i_en) begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

endmodule

// File: rtl/glb_read.sv
// glb_read: arms on a flush pulse, captures up to tx_size stream words into
// an internal buffer, stops on the count or on the done token, and exposes a
// registered backdoor read port. Optional random stall: GLB_READ_STALL_EN.
module glb_read
    import glb_pkg::*;
#(
    parameter int          DEPTH      = 2048,
    parameter logic [15:0] STALL_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    glb_read_if.slave  bus
);

    localparam int                   AW      = $clog2(DEPTH);
    localparam logic [GLB_CNT_W-1:0] DEPTH_C = GLB_CNT_W'(DEPTH);

    // A zero seed would lock the stall LFSR at zero forever.
    if (STALL_SEED == 16'h0) begin : g_bad_seed
        $error("glb_read: STALL_SEED must be non-zero");
    end

    glb_rd_state_t         r_state;
    glb_rd_state_t         w_state_nxt;
    logic                  r_ready;
    logic                  w_ready_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic [GLB_CNT_W-1:0]  r_num_rx;
    logic [GLB_CNT_W-1:0]  w_num_rx_nxt;
    logic [GLB_CNT_W-1:0]  r_tx_lim;
    logic [GLB_CNT_W-1:0]  w_tx_lim_nxt;
    logic [GLB_CNT_W-1:0]  w_lim;
    logic [GLB_CNT_W-1:0]  w_num_rx_inc;
    logic                  w_xfer;
    logic                  w_is_token;
    logic                  w_arm;
    logic                  w_stall;
    logic [GLB_DATA_W-1:0] r_mem [DEPTH];
    logic [GLB_DATA_W-1:0] r_rd_data;

`ifdef GLB_READ_STALL_EN
    logic [15:0] w_lfsr;

    glb_lfsr #(
        .SEED (STALL_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_en    (1'b1),
        .o_value (w_lfsr)
    );

    // Stall one cycle in eight; an all-zero register cannot occur from a
    // non-zero seed, so the reduction term only guards that lockup value.
    assign w_stall = (w_lfsr[3:0] < 4'd2) && (|w_lfsr);
`else
    assign w_stall = 1'b0;
`endif

    assign w_lim        = glb_clamp_lim(bus.tx_size, DEPTH_C);
    assign w_xfer       = bus.valid && r_ready;
    assign w_is_token   = (bus.data == GLB_DONE_TOKEN);
    assign w_num_rx_inc = r_num_rx + GLB_CNT_W'(1);
    assign w_arm        = (r_state == FLUSH) && !bus.flush;

    // Next state, counters, sticky done and registered ready.
    always_comb begin
        w_state_nxt  = r_state;
        w_num_rx_nxt = r_num_rx;
        w_tx_lim_nxt = r_tx_lim;
        w_done_nxt   = r_done;

        if (bus.flush) begin
            w_state_nxt = FLUSH;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = IDLE;
                FLUSH:   w_state_nxt = (w_lim == '0) ? DONE : RECV;
                RECV: begin
                    if (w_xfer && ((w_num_rx_inc == r_tx_lim) || w_is_token)) begin
                        w_state_nxt = DONE;
                    end
                end
                DONE:    w_state_nxt = DONE;
                default: w_state_nxt = IDLE;
            endcase
        end

        if (w_arm) begin
            w_tx_lim_nxt = w_lim;
            w_num_rx_nxt = '0;
            w_done_nxt   = (w_lim == '0);
        end else begin
            if (w_xfer && (r_num_rx != DEPTH_C)) begin
                w_num_rx_nxt = w_num_rx_inc;
            end
            if (w_state_nxt == DONE) begin
                w_done_nxt = 1'b1;
            end
        end

        w_ready_nxt = (w_state_nxt == RECV) && (w_num_rx_nxt < w_tx_lim_nxt) && !w_stall;
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
            r_num_rx <= '0;
            r_tx_lim <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ready  <= w_ready_nxt;
            r_done   <= w_done_nxt;
            r_num_rx <= w_num_rx_nxt;
            r_tx_lim <= w_tx_lim_nxt;
        end
    end

    // Capture write port; contents survive reset, writes are blocked during it.
    always_ff @(posedge clk) begin
        if (w_xfer && !rst) begin
            r_mem[r_num_rx[AW-1:0]] <= bus.data;
        end
    end

    // Backdoor read port with one cycle of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[bus.rd_addr[AW-1:0]];
        end
    end

    assign bus.ready     = r_ready;
    assign bus.done      = r_done;
    assign bus.num_rx    = r_num_rx;
    assign bus.rd_data   = r_rd_data;
    assign bus.dbg_state = r_state;

endmodule

// File: doc/glb_read.md
GLB_READ -- requirements
Module: glb_read

Interface
REQ-001 Parameter DEPTH, default 2048: capture buffer depth in words; power of two.
REQ-002 Parameter STALL_SEED, default 16'hACE1: non-zero LFSR seed used only when GLB_READ_STALL_EN is defined.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 flush  input  1  arm strobe; a capture run starts on its falling edge.
REQ-006 tx_size  input  12  expected word count; sampled on the flush falling edge.
REQ-007 data  input  17  stream word; bit 16 = token flag, bits 15:0 = payload.
REQ-008 valid  input  1  upstream word-valid.
REQ-009 ready  output  1  sink can accept a word this cycle.
REQ-010 done  output  1  capture run complete; sticky.
REQ-011 num_rx  output  12  count of words accepted in the current run.
REQ-012 rd_addr  input  11  backdoor read address into the capture buffer.
REQ-013 rd_data  output  17  buffer word at rd_addr; one-cycle read latency.

Function
REQ-014 Transfer occurs on a posedge where valid=1 and ready=1; word is written to buffer[num_rx], and num_rx increments by 1 in the same edge.
REQ-015 FSM states: IDLE, FLUSH, RECV, DONE.
REQ-016 IDLE -> FLUSH when flush=1; any state -> FLUSH when flush=1.
REQ-017 FLUSH -> RECV when flush=0; on this edge latch tx_lim = min(tx_size, DEPTH), clear num_rx, clear done.
REQ-018 FLUSH -> DONE instead of RECV when the latched tx_lim is 0.
REQ-019 RECV -> DONE on the transfer that makes num_rx equal tx_lim.
REQ-020 RECV -> DONE on a transfer of the done token 17'h10100; the token is stored and counted.
REQ-021 In DONE, done=1 and ready=0 until flush or rst; valid is ignored.
REQ-022 ready is registered: ready=1 only in RECV, with num_rx+transfer < tx_lim and not stalled; it drops in the cycle after the final transfer, and no extra transfer is accepted.
REQ-023 Words presented while ready=0 are not captured, and no state changes.
REQ-024 flush=1 mid-RECV aborts the run: ready=0 next cycle, num_rx is preserved until the flush falling edge, and buffer contents are preserved.
REQ-025 rd_data is registered: rd_data = buffer[rd_addr] one cycle later, in any state; reads never disturb capture.
REQ-026 num_rx saturates at DEPTH and never wraps.

Reset
REQ-027 On rst=1 at posedge: state=IDLE, ready=0, done=0, num_rx=0, tx_lim=0, rd_data=0, LFSR=STALL_SEED; buffer contents are not reset.
REQ-028 rst has priority over flush and transfers in the same cycle.

Configuration
REQ-029 Macro GLB_READ_STALL_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle; ready is additionally forced to 0 when lfsr[3:0] < 2 (12.5% stall).
REQ-030 Macro GLB_READ_STALL_EN undefined: no LFSR is built, and ready depends only on REQ-022.

Structure
REQ-031 Package glb_pkg holds GLB_DATA_W=17, GLB_DONE_TOKEN=17'h10100, and the state enum typedef glb_rd_state_t.
REQ-032 Single sub-module glb_lfsr (16-bit, seed parameter, enable input) is instantiated only under GLB_READ_STALL_EN.
REQ-033 The capture buffer is an inferred single-write, single-read synchronous RAM inside glb_read.

Verification
REQ-034 Flush pulse, tx_size=4, valid held high with words 1,2,3,4 -> four transfers, num_rx=4, done=1, ready=0 on the cycle after word 4; rd_addr=2 returns 3.
REQ-035 tx_size=10, stream 5,6,17'h10100 -> num_rx=3, done=1, buffer[2]=17'h10100.
REQ-036 tx_size=0 -> DONE on the cycle after the flush falling edge, ready never 1, num_rx=0.
REQ-037 tx_size=8, flush reasserted after 3 transfers -> ready=0 next cycle; after the flush falls, num_rx=0 and a new run captures 8 words starting at address 0.
REQ-038 tx_size=4095 with DEPTH=2048 -> exactly 2048 transfers, then done=1 and num_rx=2048.
REQ-039 rst asserted mid-RECV after 5 transfers -> next cycle state=IDLE, ready=0, done=0, num_rx=0; with GLB_READ_STALL_EN, 1000 valid-high cycles give a ready-low fraction between 8% and 17%.
